fetch_bundle_sequencer: RTL
===========================

Name: fetch_bundle_sequencer

Overview:
- Sits between the IF/ID pipeline register (4-instruction fetch bundle plus bundle PC) and the single-issue decode/dispatch stage.
- Selects one instruction per cycle from the current bundle, starting at the slot addressed by PC[3:2], and optionally skips zero words (NOPs).
- Drives the IF/ID stall input to hold the bundle until its last eligible slot is accepted, so fetch advances exactly once per consumed bundle.
- Maintains a wrapping count of issued instructions.

Parameters:
- SKIP_NOP, 1, when 1 slots holding 32'd0 are never issued; when 0 every slot from the start slot is issued.
- CNT_W, 32, width of the issued-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ID_inst_en  in  1  bundle valid, from IF/ID.
- ID_PC  in  32  bundle PC, from IF/ID; bits [3:2] give the first live slot.
- ID_inst1..ID_inst4  in  32 each  bundle slots 0..3, from IF/ID.
- flush  in  1  pipeline redirect, shared with IF/ID flush.
- dec_ready  in  1  decode/dispatch accepts issue this cycle.
- if_id_stall  out  1  hold IF/ID contents (wired to IF/ID stall).
- issue_valid  out  1  issue_inst/issue_pc are valid.
- issue_inst  out  32  selected instruction.
- issue_pc  out  32  {ID_PC[31:4], issue_slot, 2'b00}.
- issue_slot  out  2  selected slot index.
- issue_cnt  out  CNT_W  number of accepted issues, wraps modulo 2^CNT_W.

Behaviour:
- Registered state:
  - mid_q: mid-bundle flag.
  - ptr_q[1:0]: next slot to examine.
  - issue_cnt.
- Reset (rst=0, asynchronous): mid_q=0, ptr_q=0, issue_cnt=0. While rst=0, issue_valid=0, if_id_stall=0, issue_inst=0, issue_pc=0, issue_slot=0.
- Combinational, zero latency from the IF/ID outputs:
  - start = mid_q ? ptr_q : ID_PC[3:2].
  - A slot is eligible if its index >= start and (SKIP_NOP==0 or its instruction != 0).
  - sel = lowest eligible slot. found = any eligible slot. more = any eligible slot above sel.
  - issue_valid = ID_inst_en & found & !flush.
  - issue_inst and issue_slot come from sel.
  - if_id_stall = ID_inst_en & found & !flush & (more | !dec_ready).
- An instruction is accepted when issue_valid & dec_ready. On acceptance, issue_cnt increments by 1 (all ones wraps to 0).
- State update, in priority order:
  - flush=1: mid_q<=0, ptr_q<=0. No acceptance that cycle. Flush beats dec_ready, and the stall is released.
  - accepted & more: mid_q<=1, ptr_q<=sel+1. sel<=2 is guaranteed here, so there is no wrap.
  - accepted & !more: mid_q<=0. The bundle is consumed, the stall is low, and IF/ID loads the next bundle on the same edge.
  - ID_inst_en & !found (all remaining slots are NOPs): mid_q<=0, no issue, stall low, and the bundle is discarded this cycle.
  - otherwise (dec_ready=0, or ID_inst_en=0): hold.
- Back-pressure: with dec_ready=0, the outputs stay stable and the stall stays high while the bundle is valid.
- ID_inst_en=0: no issue, no stall. mid_q is held, but IF/ID cannot go invalid while stalled except by flush, which clears mid_q.
- Throughput: one instruction per cycle. A bundle with n eligible slots occupies IF/ID for n cycles when dec_ready is held high.
- Reset asserted mid-bundle: the state clears immediately. After release the next bundle starts from its own PC[3:2].

Decomposition:
- Shared package:
  - SLOTS=4.
  - The slot-index width.
  - The bundle PC alignment constant (4'b0000 low bits).
  - The NOP encoding 32'h0000_0000.
- One sub-module is natural: slot_pick. It is a combinational priority finder that takes a 4-bit eligible mask and start, and returns sel, found and more.

Test Plan:
- Bundle {A,B,C,D}, PC=0x100, dec_ready=1 → issues A,B,C,D at pc 0x100,0x104,0x108,0x10C on 4 consecutive cycles; stall=1,1,1,0; issue_cnt=4.
- PC=0x208, slots {X,Y,E,F} → only E@0x208 and F@0x20C issue; stall=1 then 0; X and Y never appear.
- SKIP_NOP=1, bundle {A,0,0,D} at PC=0x300 → A@0x300, then D@0x30C on the next cycle; bundle {0,0,0,0} → no issue, stall=0, discarded in 1 cycle.
- dec_ready=0 for 3 cycles on slot 1 → issue_inst=B held, stall=1 throughout; after dec_ready=1, B is accepted once and issue_cnt increments by exactly 1.
- flush asserted while slot 2 is pending → issue_valid=0 and stall=0 that cycle; next bundle at PC=0x404 starts at slot 1.
- rst pulsed low mid-bundle, and issue_cnt preset to 2^CNT_W-1 followed by one accept → outputs 0 immediately on reset; counter wraps to 0.

Source files
------------

// File: rtl/fetch_bundle_sequencer_pkg.sv
// Shared constants and types for the fetch bundle sequencer.
package fetch_bundle_sequencer_pkg;

  localparam int unsigned SLOTS  = 4;
  localparam int unsigned SLOT_W = $clog2(SLOTS);

  // A bundle PC is 16-byte aligned; the low nibble carries the start slot only.
  localparam logic [3:0]  PC_ALIGN = 4'b0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  typedef logic [SLOT_W-1:0] slot_t;
  typedef logic [SLOTS-1:0]  slot_mask_t;

  // Byte address of a slot within the bundle that starts at base.
  function automatic logic [31:0] slot_pc(input logic [31:0] base, input slot_t slot);
    logic [31:0] r_pc;
    r_pc       = base;
    r_pc[3:0]  = PC_ALIGN;
    r_pc[3:2]  = slot;
    return r_pc;
  endfunction

endpackage

// File: rtl/fetch_bundle_sequencer_if.sv
// IF/ID bundle input, decode handshake and issue outputs of the sequencer.
interface fetch_bundle_sequencer_if
  import fetch_bundle_sequencer_pkg::*;
();

  logic                   id_inst_en;
  logic [31:0]            id_pc;
  logic [SLOTS-1:0][31:0] id_inst;     // [0] is ID_inst1
  logic                   flush;
  logic                   dec_ready;
  logic                   if_id_stall;
  logic                   issue_valid;
  logic [31:0]            issue_inst;
  logic [31:0]            issue_pc;
  slot_t                  issue_slot;

  // Pipeline side: IF/ID register plus decode/dispatch.
  modport master (
    output id_inst_en, id_pc, id_inst, flush, dec_ready,
    input  if_id_stall, issue_valid, issue_inst, issue_pc, issue_slot
  );

  // Sequencer side.
  modport slave (
    input  id_inst_en, id_pc, id_inst, flush, dec_ready,
    output if_id_stall, issue_valid, issue_inst, issue_pc, issue_slot
  );

endinterface

// File: rtl/fetch_bundle_sequencer_slot_pick.sv
// Priority finder: lowest eligible slot at or above the start slot.
module fetch_bundle_sequencer_slot_pick
  import fetch_bundle_sequencer_pkg::*;
(
  input  slot_mask_t i_mask,
  input  slot_t      i_start,
  output slot_t      o_sel,
  output logic       o_found,
  output logic       o_more
);

  // Ascending scan: first hit is sel, any later hit means more work remains.
  always_comb begin
    o_sel   = '0;
    o_found = 1'b0;
    o_more  = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (i_mask[i] && (slot_t'(i) >= i_start)) begin
        if (!o_found) begin
          o_sel   = slot_t'(i);
          o_found = 1'b1;
        end else begin
          o_more  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fetch_bundle_sequencer.sv
// Issues one instruction per cycle from a 4-slot fetch bundle, holding IF/ID
// until the last eligible slot is accepted.
module fetch_bundle_sequencer
  import fetch_bundle_sequencer_pkg::*;
#(
  parameter bit          SKIP_NOP = 1'b1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  fetch_bundle_sequencer_if.slave      io_bus,
  output logic [CNT_W-1:0]             o_issue_cnt
);

  logic             r_mid;
  slot_t            r_ptr;
  logic [CNT_W-1:0] r_cnt;

  slot_t            w_start;
  slot_mask_t       w_mask;
  slot_t            w_sel;
  logic             w_found;
  logic             w_more;
  logic             w_live;
  logic             w_accept;
  logic             w_mid_nxt;
  slot_t            w_ptr_nxt;

  assign w_start = r_mid ? r_ptr : io_bus.id_pc[3:2];

  // Per-slot eligibility ignoring the start slot; slot_pick applies that.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < SLOTS; i++) begin
      w_mask[i] = !SKIP_NOP || (io_bus.id_inst[i] != NOP);
    end
  end

  fetch_bundle_sequencer_slot_pick u_slot_pick (
    .i_mask  (w_mask),
    .i_start (w_start),
    .o_sel   (w_sel),
    .o_found (w_found),
    .o_more  (w_more)
  );

  assign w_live   = io_bus.id_inst_en & w_found & ~io_bus.flush;
  assign w_accept = w_live & io_bus.dec_ready;

  // Outputs are forced to zero while reset is asserted, independent of the clock.
  always_comb begin
    io_bus.issue_valid = 1'b0;
    io_bus.if_id_stall = 1'b0;
    io_bus.issue_inst  = '0;
    io_bus.issue_pc    = '0;
    io_bus.issue_slot  = '0;
    if (i_rst_n) begin
      io_bus.issue_valid = w_live;
      io_bus.if_id_stall = w_live & (w_more | ~io_bus.dec_ready);
      io_bus.issue_inst  = io_bus.id_inst[w_sel];
      io_bus.issue_pc    = slot_pc(io_bus.id_pc, w_sel);
      io_bus.issue_slot  = w_sel;
    end
  end

  // Next-state for the mid-bundle flag and slot pointer, flush first.
  always_comb begin
    w_mid_nxt = r_mid;
    w_ptr_nxt = r_ptr;
    if (io_bus.flush) begin
      w_mid_nxt = 1'b0;
      w_ptr_nxt = '0;
    end else if (w_accept && w_more) begin
      // more implies sel <= 2, so the increment cannot wrap.
      w_mid_nxt = 1'b1;
      w_ptr_nxt = w_sel + slot_t'(1);
    end else if (w_accept) begin
      w_mid_nxt = 1'b0;
    end else if (io_bus.id_inst_en && !w_found) begin
      // Only NOPs left: drop the bundle this cycle.
      w_mid_nxt = 1'b0;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mid <= 1'b0;
      r_ptr <= '0;
    end else begin
      r_mid <= w_mid_nxt;
      r_ptr <= w_ptr_nxt;
    end
  end

  // Accepted-issue counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_issue_cnt = r_cnt;

endmodule
